// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard control for the 5-stage pipeline.
// Tracks EX/MEM/WB destinations in a private shadow pipeline.
module fwd_hazard_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  rf_bypass_a,
    output logic                  rf_bypass_b,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [1:0] SelRf  = 2'b00;
    localparam logic [1:0] SelMem = 2'b01;
    localparam logic [1:0] SelEx  = 2'b10;

    logic                  ex_valid, ex_rw, ex_mr;
    logic [REG_ADDR_W-1:0] ex_dst;
    logic                  mem_valid, mem_rw;
    logic [REG_ADDR_W-1:0] mem_dst;
    logic                  wb_valid, wb_rw;
    logic [REG_ADDR_W-1:0] wb_dst;

    logic                  ex_valid_d, ex_rw_d, ex_mr_d;
    logic [REG_ADDR_W-1:0] ex_dst_d;
    logic [1:0]            fwd_a_d, fwd_b_d;
    logic                  hazard;

    function automatic logic hit(input logic v, input logic rw,
                                 input logic [REG_ADDR_W-1:0] dst,
                                 input logic [REG_ADDR_W-1:0] r);
        return v & rw & (dst != '0) & (dst == r);
    endfunction

    always_comb begin
        hazard = id_valid & ex_valid & ex_mr & (ex_dst != '0) &
                 ((id_uses_rs & (ex_dst == id_rs)) | (id_uses_rt & (ex_dst == id_rt)));
        stall  = hazard & ~flush;
        rf_bypass_a = id_uses_rs & hit(wb_valid, wb_rw, wb_dst, id_rs);
        rf_bypass_b = id_uses_rt & hit(wb_valid, wb_rw, wb_dst, id_rt);
    end

    // Youngest producer (EX) takes priority over MEM; a bubble gets the RF operand.
    always_comb begin
        fwd_a_d = SelRf;
        fwd_b_d = SelRf;
        if (id_valid && id_uses_rs) begin
            if (hit(ex_valid, ex_rw, ex_dst, id_rs))         fwd_a_d = SelEx;
            else if (hit(mem_valid, mem_rw, mem_dst, id_rs)) fwd_a_d = SelMem;
        end
        if (id_valid && id_uses_rt) begin
            if (hit(ex_valid, ex_rw, ex_dst, id_rt))         fwd_b_d = SelEx;
            else if (hit(mem_valid, mem_rw, mem_dst, id_rt)) fwd_b_d = SelMem;
        end
        if (flush || stall) begin
            fwd_a_d = SelRf;
            fwd_b_d = SelRf;
        end
    end

    always_comb begin
        ex_valid_d = id_valid;
        ex_dst_d   = id_dst;
        ex_rw_d    = id_regwrite & id_valid;
        ex_mr_d    = id_memread & id_valid;
        if (flush || stall) begin
            ex_valid_d = 1'b0;
            ex_dst_d   = '0;
            ex_rw_d    = 1'b0;
            ex_mr_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_dst      <= '0;
            ex_rw       <= 1'b0;
            ex_mr       <= 1'b0;
            mem_valid   <= 1'b0;
            mem_dst     <= '0;
            mem_rw      <= 1'b0;
            wb_valid    <= 1'b0;
            wb_dst      <= '0;
            wb_rw       <= 1'b0;
            fwd_a       <= SelRf;
            fwd_b       <= SelRf;
            stall_count <= '0;
        end else begin
            wb_valid  <= mem_valid;
            wb_dst    <= mem_dst;
            wb_rw     <= mem_rw;
            mem_valid <= ex_valid;
            mem_dst   <= ex_dst;
            mem_rw    <= ex_rw;
            ex_valid  <= ex_valid_d;
            ex_dst    <= ex_dst_d;
            ex_rw     <= ex_rw_d;
            ex_mr     <= ex_mr_d;
            fwd_a     <= fwd_a_d;
            fwd_b     <= fwd_b_d;
            if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; narrow counter so saturation is reachable.
module tb_fwd_hazard_unit;

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, flush;
    logic [RW-1:0] id_rs, id_rt, id_dst;
    logic          stall, rf_bypass_a, rf_bypass_b;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_count;

    int n_assert = 0;
    int n_fail   = 0;

    fwd_hazard_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_dst      (id_dst),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .stall       (stall),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .rf_bypass_a (rf_bypass_a),
        .rf_bypass_b (rf_bypass_b),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic urs,
                         input logic urt, input logic [RW-1:0] dst, input logic rw,
                         input logic mr);
        id_valid = 1'b1;
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dst = dst; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic idle();
        id_valid = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_dst = '0; id_regwrite = 1'b0; id_memread = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_fwd_a", fwd_a, 0);
        chk("reset_fwd_b", fwd_b, 0);
        chk("reset_stall", stall, 0);
        chk("reset_count", stall_count, 0);

        // EX/MEM forward: add $3 then sub reading $3
        instr(1, 2, 1, 1, 3, 1, 0); step();
        instr(3, 1, 1, 1, 10, 1, 0); step();
        chk("exmem_fwd_a", fwd_a, 2'b10);
        chk("exmem_fwd_b", fwd_b, 2'b00);

        // MEM/WB forward through one unrelated instruction
        instr(1, 2, 1, 1, 3, 1, 0); step();
        instr(1, 2, 1, 1, 9, 1, 0); step();
        instr(1, 3, 1, 1, 10, 0, 0); step();
        chk("memwb_fwd_b", fwd_b, 2'b01);
        chk("memwb_fwd_a", fwd_a, 2'b00);

        // $0 never forwards
        instr(1, 2, 1, 1, 0, 1, 0); step();
        instr(1, 2, 1, 1, 0, 1, 0); step();
        instr(0, 0, 1, 1, 10, 0, 0); step();
        chk("r0_fwd_a", fwd_a, 2'b00);
        chk("r0_fwd_b", fwd_b, 2'b00);

        // Youngest producer wins
        instr(1, 2, 1, 1, 5, 1, 0); step();
        instr(1, 2, 1, 1, 5, 1, 0); step();
        instr(5, 2, 1, 1, 10, 0, 0); step();
        chk("prio_fwd_a", fwd_a, 2'b10);

        // Load-use: one stall, bubble, then MEM/WB forward
        instr(1, 2, 1, 0, 4, 1, 1); step();
        chk("lu_count_before", stall_count, 0);
        instr(4, 2, 1, 1, 6, 1, 0); #1;
        chk("lu_stall_on", stall, 1);
        step();
        chk("lu_stall_off", stall, 0);
        chk("lu_bubble_fwd_a", fwd_a, 2'b00);
        chk("lu_count", stall_count, 1);
        step();
        chk("lu_replay_fwd_a", fwd_a, 2'b01);
        chk("lu_count_hold", stall_count, 1);

        // Flush overrides the hazard
        instr(1, 2, 1, 0, 4, 1, 1); step();
        instr(4, 2, 1, 1, 6, 1, 0); flush = 1'b1; #1;
        chk("flush_stall", stall, 0);
        step();
        flush = 1'b0;
        chk("flush_count", stall_count, 1);
        chk("flush_fwd_a", fwd_a, 2'b00);
        idle(); step();

        // WB bypass: producer of $7 reaches WB while ID reads $7
        instr(1, 2, 1, 1, 7, 1, 0); step();
        idle(); step();
        idle(); step();
        instr(1, 7, 1, 1, 10, 0, 0); #1;
        chk("wb_bypass_b", rf_bypass_b, 1);
        chk("wb_bypass_a", rf_bypass_a, 0);
        step();
        chk("wb_fwd_b", fwd_b, 2'b00);
        idle(); step();

        // Saturation: 14 more stalls reach all-ones, further stalls must not wrap
        for (int i = 0; i < 20; i++) begin
            instr(1, 2, 1, 0, 4, 1, 1); step();
            instr(4, 2, 1, 1, 6, 1, 0); step();
            step();
            if (i == 13) chk("sat_reach", stall_count, 15);
        end
        chk("sat_hold", stall_count, 15);

        // Asynchronous reset mid-stream with a pending load-use hazard
        instr(1, 2, 1, 1, 3, 1, 0); step();
        instr(1, 2, 1, 0, 4, 1, 1); step();
        instr(4, 3, 1, 1, 6, 1, 0); #1;
        chk("pre_rst_stall", stall, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_fwd_b", fwd_b, 0);
        chk("rst_count", stall_count, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_fwd_a", fwd_a, 2'b00);
        chk("post_rst_fwd_b", fwd_b, 2'b00);
        chk("post_rst_count", stall_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
